expr_lane_pipe: RTL and testbench

- Parametrised, registered successor to our flat combinational mixed-sign expression blocks.
- Evaluates one selectable operator across LANES independent operand pairs.
- Operands are WIDTH bits, with signedness fixed per instance.
- Results pass through a PIPE-deep elastic valid/ready pipeline and leave on a packed bus with lane 0 in the MSBs, the same packing as our y-vector blocks.

---
 rtl/expr_lane_pipe.sv | 104 ++++++++++
 tb/tb_expr_lane_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/expr_lane_pipe.sv
// expr_lane_pipe: per-lane operator evaluation over packed operand pairs feeding an elastic valid/ready pipeline
module expr_lane_pipe #(
  parameter int LANES  = 6,
  parameter int WIDTH  = 6,
  parameter int SIGNED = 1,
  parameter int PIPE   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             op,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] y,
  output logic [LANES-1:0]       ovf,
  output logic [15:0]            done_cnt
);
  localparam int N  = LANES*WIDTH;
  localparam int SW = $clog2(WIDTH)+1;
  logic [N-1:0]     ry;
  logic [LANES-1:0] ro;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0]        av, bv, r;
    logic signed [WIDTH-1:0] sa;
    logic [SW-1:0]           sh;
    logic signed [WIDTH:0]   ea, eb, full;
    assign av = a[(LANES-1-l)*WIDTH +: WIDTH];
    assign bv = b[(LANES-1-l)*WIDTH +: WIDTH];
    assign sa = av;
    assign sh = bv[SW-1:0];
    assign ea = (SIGNED != 0) ? {av[WIDTH-1], av} : {1'b0, av};
    assign eb = (SIGNED != 0) ? {bv[WIDTH-1], bv} : {1'b0, bv};
    // shifts by >= WIDTH saturate naturally to sign fill / zero
    always_comb begin
      full = '0;
      r = '0;
      case (op)
        4'd0: begin full = ea + eb; r = full[WIDTH-1:0]; end
        4'd1: begin full = ea - eb; r = full[WIDTH-1:0]; end
        4'd2: r = av & bv;
        4'd3: r = av ~^ bv;
        4'd4: if (SIGNED != 0) r = sa >>> sh; else r = av >> sh;
        4'd5: r = av << sh;
        4'd6: r = {{(WIDTH-1){1'b0}}, ea >= eb};
        4'd7: r = {{(WIDTH-1){1'b0}}, av == bv};
        4'd8: r = (|bv) ? av : ~av;
        4'd9: r = {{(WIDTH-1){1'b0}}, ~&av};
        4'd10: r = {{(WIDTH-1){1'b0}}, (|av) && (|bv)};
        4'd11: begin full = -ea; r = full[WIDTH-1:0]; end
        default: r = '0;
      endcase
    end
    assign ry[(LANES-1-l)*WIDTH +: WIDTH] = r;
    assign ro[LANES-1-l] = full != ((SIGNED != 0) ? {full[WIDTH-1], full[WIDTH-1:0]} : {1'b0, full[WIDTH-1:0]});
  end
  logic [PIPE-1:0]  v, ld;
  logic [N-1:0]     sy [PIPE];
  logic [LANES-1:0] so [PIPE];
  logic             acc;
  // a stage may load if any stage at or after it is empty, or the output drains
  always_comb begin
    ld = '0;
    acc = out_ready;
    for (int i = PIPE-1; i >= 0; i--) begin
      acc = acc | ~v[i];
      ld[i] = acc;
    end
  end
  for (genvar s = 0; s < PIPE; s++) begin : g_st
    if (s == 0) begin : g_h
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v[s] <= 1'b0;
          sy[s] <= '0;
          so[s] <= '0;
        end else if (ld[s]) begin
          v[s] <= in_valid;
          sy[s] <= ry;
          so[s] <= ro;
        end
    end else begin : g_t
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v[s] <= 1'b0;
          sy[s] <= '0;
          so[s] <= '0;
        end else if (ld[s]) begin
          v[s] <= v[s-1];
          sy[s] <= sy[s-1];
          so[s] <= so[s-1];
        end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) done_cnt <= '0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + 16'd1;
  assign in_ready  = ld[0];
  assign out_valid = v[PIPE-1];
  assign y         = sy[PIPE-1];
  assign ovf       = so[PIPE-1];
endmodule

// File: tb/tb_expr_lane_pipe.sv
// tb_expr_lane_pipe: directed table, backpressure, reset and randomised scoreboard checks on signed and unsigned instances
module tb_expr_lane_pipe;
  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready;
  logic [3:0] op;
  logic [35:0] a, b;
  logic in_ready_s, out_valid_s, in_ready_u, out_valid_u;
  logic [35:0] y_s, y_u;
  logic [5:0] ovf_s, ovf_u;
  logic [15:0] done_s, done_u;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  expr_lane_pipe #(.LANES(6), .WIDTH(6), .SIGNED(1), .PIPE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .op(op), .a(a), .b(b),
    .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s), .ovf(ovf_s), .done_cnt(done_s));
  expr_lane_pipe #(.LANES(6), .WIDTH(6), .SIGNED(0), .PIPE(2)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u), .op(op), .a(a), .b(b),
    .out_valid(out_valid_u), .out_ready(out_ready), .y(y_u), .ovf(ovf_u), .done_cnt(done_u));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] lane_m(input logic [3:0] o, input logic [5:0] x, input logic [5:0] z, input bit sg);
    int ia, ib, res, sh;
    logic ov;
    ia = sg ? int'($signed(x)) : int'(x);
    ib = sg ? int'($signed(z)) : int'(z);
    sh = int'(z[3:0]);
    ov = 1'b0;
    case (o)
      0: res = ia + ib;
      1: res = ia - ib;
      11: res = -ia;
      2: res = ia & ib;
      3: res = ~(ia ^ ib);
      4: res = (sh >= 6) ? ((ia < 0) ? -1 : 0) : (ia >>> sh);
      5: res = (sh >= 6) ? 0 : (ia << sh);
      6: res = (ia >= ib) ? 1 : 0;
      7: res = (x == z) ? 1 : 0;
      8: res = (z != 0) ? ia : ~ia;
      9: res = (x != 6'h3f) ? 1 : 0;
      10: res = (x != 0 && z != 0) ? 1 : 0;
      default: res = 0;
    endcase
    if (o == 0 || o == 1 || o == 11) ov = sg ? (res < -32 || res > 31) : (res < 0 || res > 63);
    return {ov, res[5:0]};
  endfunction

  function automatic logic [41:0] model_bus(input logic [3:0] o, input logic [35:0] x, input logic [35:0] z, input bit sg);
    logic [35:0] yy;
    logic [5:0] oo;
    logic [6:0] m;
    for (int l = 0; l < 6; l++) begin
      m = lane_m(o, x[(5-l)*6 +: 6], z[(5-l)*6 +: 6], sg);
      yy[(5-l)*6 +: 6] = m[5:0];
      oo[5-l] = m[6];
    end
    return {oo, yy};
  endfunction

  typedef struct {
    logic [3:0] op;
    logic [5:0] a0, b0, a1, b1, ys0, ys1;
    logic os0, os1;
    logic [5:0] yu0, yu1;
    logic ou0, ou1;
  } vec_t;
  vec_t vt [16];

  typedef struct packed {
    logic [41:0] s;
    logic [41:0] u;
  } exp_t;
  exp_t q[$];

  logic [35:0] ba [4], bb [4];
  logic [41:0] be [4];
  logic acc;
  int nxt, sent, got, cyc;

  initial begin
    vt[0]  = '{4'd0,  6'b111011, 6'b000011, 6'b011111, 6'b000001, 6'b111110, 6'b100000, 1'b0, 1'b1, 6'b111110, 6'b100000, 1'b0, 1'b0};
    vt[1]  = '{4'd4,  6'b110000, 6'b000010, 6'b110000, 6'b000111, 6'b111100, 6'b111111, 1'b0, 1'b0, 6'b001100, 6'b000000, 1'b0, 1'b0};
    vt[2]  = '{4'd6,  6'b111111, 6'b000001, 6'b000010, 6'b000010, 6'b000000, 6'b000001, 1'b0, 1'b0, 6'b000001, 6'b000001, 1'b0, 1'b0};
    vt[3]  = '{4'd13, 6'b111111, 6'b000001, 6'b000101, 6'b000011, 6'b000000, 6'b000000, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0};
    vt[4]  = '{4'd1,  6'b100000, 6'b000001, 6'b000011, 6'b000101, 6'b011111, 6'b111110, 1'b1, 1'b0, 6'b011111, 6'b111110, 1'b0, 1'b1};
    vt[5]  = '{4'd11, 6'b100000, 6'b000000, 6'b000000, 6'b000000, 6'b100000, 6'b000000, 1'b1, 1'b0, 6'b100000, 6'b000000, 1'b1, 1'b0};
    vt[6]  = '{4'd5,  6'b000011, 6'b000100, 6'b000001, 6'b000110, 6'b110000, 6'b000000, 1'b0, 1'b0, 6'b110000, 6'b000000, 1'b0, 1'b0};
    vt[7]  = '{4'd2,  6'b101010, 6'b110011, 6'b001111, 6'b111100, 6'b100010, 6'b001100, 1'b0, 1'b0, 6'b100010, 6'b001100, 1'b0, 1'b0};
    vt[8]  = '{4'd3,  6'b101010, 6'b110011, 6'b000000, 6'b111111, 6'b100110, 6'b000000, 1'b0, 1'b0, 6'b100110, 6'b000000, 1'b0, 1'b0};
    vt[9]  = '{4'd7,  6'b010101, 6'b010101, 6'b010101, 6'b010100, 6'b000001, 6'b000000, 1'b0, 1'b0, 6'b000001, 6'b000000, 1'b0, 1'b0};
    vt[10] = '{4'd8,  6'b001100, 6'b000000, 6'b001100, 6'b100000, 6'b110011, 6'b001100, 1'b0, 1'b0, 6'b110011, 6'b001100, 1'b0, 1'b0};
    vt[11] = '{4'd9,  6'b111111, 6'b000000, 6'b111110, 6'b000000, 6'b000000, 6'b000001, 1'b0, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b0};
    vt[12] = '{4'd10, 6'b000001, 6'b100000, 6'b000000, 6'b111111, 6'b000001, 6'b000000, 1'b0, 1'b0, 6'b000001, 6'b000000, 1'b0, 1'b0};
    vt[13] = '{4'd4,  6'b011000, 6'b000011, 6'b100000, 6'b001111, 6'b000011, 6'b111111, 1'b0, 1'b0, 6'b000011, 6'b000000, 1'b0, 1'b0};
    vt[14] = '{4'd6,  6'b100000, 6'b011111, 6'b000101, 6'b000101, 6'b000000, 6'b000001, 1'b0, 1'b0, 6'b000001, 6'b000001, 1'b0, 1'b0};
    vt[15] = '{4'd0,  6'b100000, 6'b111111, 6'b111111, 6'b000001, 6'b011111, 6'b000000, 1'b1, 1'b0, 6'b011111, 6'b000000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    #2;
    chk("rst_out_valid", out_valid_s, 1'b0);
    chk("rst_y", {ovf_s, y_s}, 42'd0);
    chk("rst_done", done_s, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready_s, 1'b1);

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      op = vt[i].op; a = {vt[i].a0, {5{vt[i].a1}}}; b = {vt[i].b0, {5{vt[i].b1}}};
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("tbl_in_ready", in_ready_s, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_lat_early", out_valid_s, 1'b0);
      @(negedge clk);
      chk("tbl_lat", out_valid_s, 1'b1);
      chk("tbl_signed", {ovf_s, y_s}, {vt[i].os0, {5{vt[i].os1}}, vt[i].ys0, {5{vt[i].ys1}}});
      chk("tbl_unsigned", {ovf_u, y_u}, {vt[i].ou0, {5{vt[i].ou1}}, vt[i].yu0, {5{vt[i].yu1}}});
    end
    @(posedge clk); #1;
    chk("tbl_done", done_s, 16'd16);

    op = 4'd0; a = {6{6'd5}}; b = {6{6'd1}}; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = {6{6'd7}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid_pre", out_valid_s, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid_s, 1'b0);
    chk("rst_mid_y", {ovf_s, y_s}, 42'd0);
    chk("rst_mid_done", done_s, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_rel_in_ready", in_ready_s, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("rst_no_stale", out_valid_s, 1'b0);
      @(negedge clk);
    end

    for (int k = 0; k < 4; k++) begin
      ba[k] = {6{6'(k + 1)}};
      bb[k] = {6{6'(k + 3)}};
      be[k] = model_bus(4'd0, ba[k], bb[k], 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = 4'd0; a = ba[0]; b = bb[0];
    @(negedge clk);
    chk("bp_in_ready1", in_ready_s, 1'b1);
    @(posedge clk); #1;
    a = ba[1]; b = bb[1];
    @(negedge clk);
    chk("bp_in_ready2", in_ready_s, 1'b1);
    @(posedge clk); #1;
    a = ba[2]; b = bb[2];
    @(negedge clk);
    chk("bp_in_ready3", in_ready_s, 1'b0);
    chk("bp_out_valid", out_valid_s, 1'b1);
    chk("bp_y_stall", {ovf_s, y_s}, be[0]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_y_stable", {ovf_s, y_s}, be[0]);
    chk("bp_in_ready_hold", in_ready_s, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    nxt = 2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_drain_valid", out_valid_s, 1'b1);
      chk("bp_drain_y", {ovf_s, y_s}, be[k]);
      acc = in_valid && in_ready_s;
      @(posedge clk); #1;
      if (acc) begin
        nxt++;
        if (nxt < 4) begin a = ba[nxt]; b = bb[nxt]; end
        else in_valid = 1'b0;
      end
    end
    chk("bp_done", done_s, 16'd4);
    chk("bp_empty", out_valid_s, 1'b0);

    sent = 0; got = 0; cyc = 0;
    while (got < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      in_valid = (sent < 10000) && ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      op = 4'($urandom_range(0, 15));
      a = 36'({$urandom(), $urandom()});
      b = 36'({$urandom(), $urandom()});
      @(negedge clk);
      cyc++;
      if (out_valid_s && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious", 1'b1, 1'b0);
        else begin
          chk("rnd_signed", {ovf_s, y_s}, q[0].s);
          chk("rnd_unsigned", {ovf_u, y_u}, q[0].u);
          void'(q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready_s) begin
        q.push_back('{model_bus(op, a, b, 1'b1), model_bus(op, a, b, 1'b0)});
        sent++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rnd_got", got, 10000);
    chk("rnd_left", q.size(), 0);
    chk("rnd_done", done_s, 16'(4 + sent));
    chk("rnd_done_u", done_u, 16'(4 + sent));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
